// File: rtl/edge_pkg.sv
// Shared definitions for the edge-window scheduler: window geometry, pixel
// type and scheduler state encoding.
package edge_pkg;

    localparam int unsigned WIN_DIM  = 5;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned WIN_BITS = WIN_DIM * WIN_DIM * PIX_W;   // 200
    localparam int unsigned ROW_BITS = WIN_DIM * PIX_W;             // 40

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/edge_line_buf.sv
// Four-line circular pixel store. All four lines share one address (the
// current column). Reads are combinational and return the old contents;
// a write shifts each line's entry one line older and stores the new pixel
// as the youngest line.
// Ports:
//   clk             system clock
//   i_we            rotate the lines at i_addr
//   i_addr          column address
//   i_wdata         incoming pixel (becomes line 3)
//   o_lb0..o_lb3    stored pixels at i_addr, o_lb0 oldest
module edge_line_buf
    import edge_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned COL_W = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [COL_W-1:0] i_addr,
    input  pix_t             i_wdata,
    output pix_t             o_lb0,
    output pix_t             o_lb1,
    output pix_t             o_lb2,
    output pix_t             o_lb3
);

    pix_t r_mem [4][IMG_W];

    assign o_lb0 = r_mem[0][i_addr];
    assign o_lb1 = r_mem[1][i_addr];
    assign o_lb2 = r_mem[2][i_addr];
    assign o_lb3 = r_mem[3][i_addr];

    // Contents are don't-care after reset, so no reset on the storage.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[0][i_addr] <= r_mem[1][i_addr];
            r_mem[1][i_addr] <= r_mem[2][i_addr];
            r_mem[2][i_addr] <= r_mem[3][i_addr];
            r_mem[3][i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/edge_window_sched.sv
// Streaming scheduler for a combinational 5x5 edge kernel over a raster
// frame. Buffers four lines plus a 5x5 shift window, presents each fully
// interior window on win_out, registers the kernel result and emits it on a
// valid/ready stream.
// Build option: EDGE_THRESH_EN adds a thresh input and binarises the output
// (kern_in >= thresh -> 8'hFF, else 8'h00).
// Ports:
//   clk, rst              clock, async active-high reset
//   start                 begin a frame (IDLE only)
//   in_valid/in_ready     input pixel handshake, in_pixel raster order
//   win_out               window: row r at [40r+39:40r], column c at +8c
//   kern_in               kernel magnitude for the current win_out
//   out_valid/out_ready   result handshake, out_pixel result
//   busy                  not IDLE
//   frame_done            pulse after the final result handshakes
module edge_window_sched
    import edge_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PIX_W-1:0]    in_pixel,
    output logic [WIN_BITS-1:0] win_out,
    input  logic [PIX_W-1:0]    kern_in,
`ifdef EDGE_THRESH_EN
    input  logic [PIX_W-1:0]    thresh,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIX_W-1:0]    out_pixel,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    sched_state_t        r_state;
    sched_state_t        w_state_nxt;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic                r_win_vld;
    logic [WIN_BITS-1:0] r_win;
    logic                r_out_valid;
    pix_t                r_out_pixel;
    logic                r_frame_done;

    logic                w_stall;
    logic                w_accept;
    logic                w_col_end;
    logic                w_last_pix;
    logic                w_last_hs;
    pix_t                w_res;
    pix_t                w_col [WIN_DIM];

    assign w_stall    = r_out_valid && !out_ready;
    assign in_ready   = (r_state == RUN) && !w_stall;
    assign w_accept   = in_valid && in_ready;
    assign w_col_end  = (r_col == COL_W'(IMG_W - 1));
    assign w_last_pix = w_col_end && (r_row == ROW_W'(IMG_H - 1));
    // Final result: handshake in DRAIN with no window still pending.
    assign w_last_hs  = (r_state == DRAIN) && r_out_valid && out_ready && !r_win_vld;

    assign busy       = (r_state != IDLE);
    assign win_out    = r_win;
    assign out_valid  = r_out_valid;
    assign out_pixel  = r_out_pixel;
    assign frame_done = r_frame_done;

`ifdef EDGE_THRESH_EN
    assign w_res = (kern_in >= thresh) ? 8'hFF : 8'h00;
`else
    assign w_res = kern_in;
`endif

    edge_line_buf #(
        .IMG_W (IMG_W),
        .COL_W (COL_W)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (in_pixel),
        .o_lb0   (w_col[0]),
        .o_lb1   (w_col[1]),
        .o_lb2   (w_col[2]),
        .o_lb3   (w_col[3])
    );
    assign w_col[4] = in_pixel;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)                   w_state_nxt = RUN;
            RUN:     if (w_accept && w_last_pix)  w_state_nxt = DRAIN;
            DRAIN:   if (w_last_hs)               w_state_nxt = IDLE;
            default:                              w_state_nxt = IDLE;
        endcase
    end

    // Stage 1: raster counters, window shift and window-valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_win_vld <= 1'b0;
            r_win     <= '0;
        end else if (r_state == IDLE && start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                r_win[r*ROW_BITS +: ROW_BITS] <= {w_col[r], r_win[r*ROW_BITS + PIX_W +: ROW_BITS - PIX_W]};
            end
            // Columns 0..3 of a line hold stale data from the previous line.
            r_win_vld <= (r_row >= ROW_W'(4)) && (r_col >= COL_W'(4));
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end else if (!w_stall) begin
            r_win_vld <= 1'b0;
        end
    end

    // Stage 2: result register, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_pixel  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_hs;
            if (!w_stall) begin
                r_out_valid <= r_win_vld;
                r_out_pixel <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_edge_window_sched.sv
// Directed bench for edge_window_sched on an 8x8 frame with a simple
// horizontal-gradient kernel: G = sum_r w_r * 4 * (p[r][4] - p[r][0]),
// w = {1,2,2,2,1}, magnitude |G| saturated to 255. A column ramp gives 128.
module tb_edge_window_sched;

    localparam int unsigned W = 8;
    localparam int unsigned H = 8;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 4) * (H - 4);

    localparam int M_FLAT = 0;
    localparam int M_HR   = 1;
    localparam int M_VR   = 2;
    localparam int M_IDX  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_pixel;
    logic [199:0] win_out;
    logic [7:0]   kern_in;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_pixel;
    logic         busy;
    logic         frame_done;
`ifdef EDGE_THRESH_EN
    logic [7:0]   thresh;
`endif

    int checks   = 0;
    int failures = 0;

    edge_window_sched #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .win_out    (win_out),
        .kern_in    (kern_in),
`ifdef EDGE_THRESH_EN
        .thresh     (thresh),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] kern(input logic [199:0] w);
        int g;
        int wt [5];
        wt = '{1, 2, 2, 2, 1};
        g = 0;
        for (int r = 0; r < 5; r++)
            g += wt[r] * 4 * (int'(w[r*40+32 +: 8]) - int'(w[r*40 +: 8]));
        if (g < 0) g = -g;
        if (g > 255) g = 255;
        return 8'(g);
    endfunction

    always_comb kern_in = kern(win_out);

    function automatic logic [7:0] pix(input int mode, input int idx);
        int x, y;
        x = idx % W;
        y = idx / W;
        case (mode)
            M_HR:    return 8'(x);
            M_VR:    return 8'(y);
            M_IDX:   return 8'(y * W + x);
            default: return 8'd50;
        endcase
    endfunction

    function automatic logic [7:0] expv(input int mode);
        logic [7:0] raw;
        raw = (mode == M_HR || mode == M_IDX) ? 8'd128 : 8'd0;
`ifdef EDGE_THRESH_EN
        return (raw >= thresh) ? 8'hFF : 8'h00;
`else
        return raw;
`endif
    endfunction

    // First interior window of the index image: element (r,c) = r*8+c.
    function automatic logic [199:0] exp_win_first();
        logic [199:0] w;
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[r*40 + c*8 +: 8] = 8'(r * W + c);
        return w;
    endfunction

    task automatic check(input string tag, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One frame: drives pixels, consumes results, optionally stalls the
    // consumer for 5 cycles at result stall_idx or resets after abort_after
    // accepted pixels.
    task automatic run_frame(input int mode, input int stall_idx, input int abort_after);
        int   idx, nout, stall_cnt, done_cnt, done_cyc, hs_cyc;
        logic win_chk, aborted;
        idx = 0; nout = 0; stall_cnt = 0; done_cnt = 0;
        done_cyc = -1; hs_cyc = -2;
        win_chk = 1'b0; aborted = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (win_chk) begin
                check("win_first", win_out, exp_win_first());
                win_chk = 1'b0;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (abort_after >= 0 && !aborted && idx == abort_after) begin
                in_valid = 1'b0;
                rst = 1'b1;
                #1;
                check("abort_busy", busy, 0);
                check("abort_in_ready", in_ready, 0);
                check("abort_out_valid", out_valid, 0);
                #1 rst = 1'b0;
                aborted = 1'b1;
            end
            out_ready = 1'b1;
            if (out_valid && nout == stall_idx && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end
            in_valid = (idx < NPIX) && !aborted;
            in_pixel = pix(mode, idx);
            #1;
            if (!out_ready) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_hold", out_pixel, expv(mode));
            end
            if (out_valid && out_ready) begin
                check("out_pix", out_pixel, expv(mode));
                nout++;
                if (nout == NOUT) hs_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                if (mode == M_IDX && idx == 4 * W + 4) win_chk = 1'b1;
                idx++;
            end
        end
        in_valid = 1'b0;
        if (abort_after < 0) begin
            check("out_count", nout, NOUT);
            check("done_count", done_cnt, 1);
            check("done_timing", done_cyc, hs_cyc + 1);
        end else begin
            check("abort_no_done", done_cnt, 0);
        end
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
`ifdef EDGE_THRESH_EN
        thresh = 8'd0;
`endif
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pixel", out_pixel, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_win_out", win_out, 0);
        @(negedge clk); rst = 1'b0;

`ifdef EDGE_THRESH_EN
        thresh = 8'd128;
        run_frame(M_HR, -1, -1);
        thresh = 8'd129;
        run_frame(M_HR, -1, -1);
        thresh = 8'd1;
        run_frame(M_FLAT, -1, -1);
`else
        run_frame(M_FLAT, -1, -1);
        run_frame(M_HR, -1, -1);
        run_frame(M_VR, -1, -1);
        run_frame(M_IDX, -1, -1);
        run_frame(M_HR, 3, -1);
        run_frame(M_HR, -1, 30);
        run_frame(M_FLAT, -1, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
